// File: rtl/mini_alu_16bit_div.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, WIDTH iterations per result.
// Latency WIDTH cycles from the accept edge (1 cycle for divide-by-zero); start is ignored while busy.
module mini_alu_16bit_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             valid,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             ge;

    // Shift the next dividend bit into the partial remainder; compare/subtract at WIDTH+1 bits.
    assign trial  = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
    assign ge     = trial >= {1'b0, d_reg};
    assign diff   = trial - {1'b0, d_reg};
    assign r_next = ge ? diff : trial;
    assign q_next = {q_reg[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (data1 == '0) begin
                            state     <= DONE;
                            quotient  <= '1;
                            remainder <= data0;
                            overflow  <= 1'b1;
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state    <= CALC;
                            d_reg    <= data1;
                            q_reg    <= data0;
                            r_reg    <= '0;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            valid    <= 1'b0;
                            overflow <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
